// File: rtl/bg_line_fetcher_if.sv
// Handshake bundle for the background line fetcher: line request, VRAM read port
// and pixel readout. master = fetcher side, slave = arbiter/mixer side.
interface bg_line_fetcher_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  line_start;
  logic [7:0]            line_y;
  logic [7:0]            scroll_x;
  logic [7:0]            scroll_y;
  logic                  busy;
  logic                  line_done;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic [7:0]            mem_data;
  logic [7:0]            px_x;
  logic [1:0]            px_pattern;
  logic [2:0]            px_color;

  modport master (
    input  line_start, line_y, scroll_x, scroll_y, mem_gnt, mem_data, px_x,
    output busy, line_done, mem_req, mem_addr, px_pattern, px_color
  );

  modport slave (
    output line_start, line_y, scroll_x, scroll_y, mem_gnt, mem_data, px_x,
    input  busy, line_done, mem_req, mem_addr, px_pattern, px_color
  );
endinterface

// File: rtl/bg_line_fetcher.sv
// Sequential background scanline fetcher: walks nametable and pattern memory over
// a shared 8-bit VRAM port into a double-buffered line store read by the mixer.
//
// state | meaning
// IDLE  | waiting for line_start
// COLOR | requesting the per-screen color byte
// NT    | requesting the nametable tile byte for entry j
// P0    | tile byte arrives; requesting the pattern hi byte
// P1    | hi byte arrives; requesting the pattern lo byte
// DONE  | last entry written, banks swap at the end of this cycle
module bg_line_fetcher #(
  parameter int COLS = 32,
  parameter int ROWS = 30,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] PMB_BASE = 12'h200,
  parameter logic [ADDR_WIDTH-1:0] NTBL_BASE = 12'h400
) (
  input logic clk,
  input logic rst,
  bg_line_fetcher_if.master bus
);
  localparam logic [8:0] LINE_H = 9'(ROWS * 8);
  localparam logic [ADDR_WIDTH-1:0] COLOR_ADDR = NTBL_BASE + ADDR_WIDTH'(ROWS * COLS);
  localparam logic [5:0] LAST_J = 6'(COLS);
  localparam logic [4:0] COL_MASK = 5'(COLS - 1);

  typedef enum logic [2:0] {IDLE, COLOR, NT, P0, P1, DONE} state_t;
  typedef enum logic [1:0] {K_COLOR, K_TILE, K_HI, K_LO} kind_t;

  state_t state;
  kind_t  cap_kind, cur_kind;
  logic   cap_vld;
  logic [5:0] j_q, cap_j;
  logic [7:0] ry_q;
  logic [4:0] coarse_q;
  logic [2:0] fine_q;
  logic [2:0] color0_q, color1_q;
  logic [7:0] tile_q, hi_q;
  logic       front_sel;
  logic [2:0] front_fine;
  logic [18:0] bank0 [0:COLS];
  logic [18:0] bank1 [0:COLS];

  logic       fire;
  logic [5:0] tile_cur;
  logic [4:0] src_col;
  logic [2:0] prow;
  logic [ADDR_WIDTH-1:0] pmb_addr, nt_addr;
  logic [8:0] ry_sum;
  logic [15:0] line_raw, line_w;
  logic [18:0] wr_ent;
  logic [8:0] e;
  logic [18:0] ent;

  function automatic logic [15:0] pair_rev(input logic [15:0] v);
    logic [15:0] r;
    for (int k = 0; k < 8; k++) r[2*k +: 2] = v[14-2*k +: 2];
    return r;
  endfunction

  // The tile byte is only on mem_data during the first P0 cycle; afterwards use the captured copy.
  assign fire     = bus.mem_req & bus.mem_gnt;
  assign tile_cur = (cap_vld && cap_kind == K_TILE) ? bus.mem_data[5:0] : tile_q[5:0];
  assign src_col  = (j_q[4:0] + coarse_q) & COL_MASK;
  assign prow     = tile_cur[5] ? ~ry_q[2:0] : ry_q[2:0];
  assign pmb_addr = PMB_BASE + ADDR_WIDTH'({tile_cur[4:0], prow, 1'b0});
  assign nt_addr  = NTBL_BASE + ADDR_WIDTH'(ry_q[7:3]) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(src_col);
  assign ry_sum   = {1'b0, bus.line_y} + {1'b0, bus.scroll_y};

  assign line_raw = {hi_q, bus.mem_data};
  assign line_w   = tile_q[6] ? pair_rev(line_raw) : line_raw;
  assign wr_ent   = {(tile_q[7] ? color1_q : color0_q), line_w};

  assign e   = {1'b0, bus.px_x} + {6'b0, front_fine};
  assign ent = front_sel ? bank1[e[8:3]] : bank0[e[8:3]];

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    cur_kind     = K_LO;
    case (state)
      COLOR: begin bus.mem_req = 1'b1; bus.mem_addr = COLOR_ADDR;   cur_kind = K_COLOR; end
      NT:    begin bus.mem_req = 1'b1; bus.mem_addr = nt_addr;      cur_kind = K_TILE;  end
      P0:    begin bus.mem_req = 1'b1; bus.mem_addr = pmb_addr;     cur_kind = K_HI;    end
      P1:    begin bus.mem_req = 1'b1; bus.mem_addr = pmb_addr + 1'b1; cur_kind = K_LO; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && cap_vld && cap_kind == K_LO) begin
      if (front_sel) bank0[cap_j] <= wr_ent;
      else           bank1[cap_j] <= wr_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.line_done  <= 1'b0;
      bus.px_pattern <= 2'd0;
      bus.px_color   <= 3'd0;
      cap_vld        <= 1'b0;
      cap_kind       <= K_COLOR;
      cap_j          <= 6'd0;
      j_q            <= 6'd0;
      front_sel      <= 1'b0;
      front_fine     <= 3'd0;
    end else begin
      cap_vld  <= fire;
      cap_kind <= cur_kind;
      cap_j    <= j_q;
      if (cap_vld) begin
        case (cap_kind)
          K_COLOR: begin color0_q <= bus.mem_data[2:0]; color1_q <= bus.mem_data[5:3]; end
          K_TILE:  tile_q <= bus.mem_data;
          K_HI:    hi_q   <= bus.mem_data;
          default: ;
        endcase
      end

      bus.px_pattern <= ent[{~e[2:0], 1'b1} -: 2];
      bus.px_color   <= ent[18:16];

      case (state)
        IDLE: begin
          bus.line_done <= 1'b0;
          if (bus.line_start) begin
            ry_q     <= 8'((ry_sum >= LINE_H) ? ry_sum - LINE_H : ry_sum);
            coarse_q <= bus.scroll_x[7:3];
            fine_q   <= bus.scroll_x[2:0];
            j_q      <= 6'd0;
            bus.busy <= 1'b1;
            state    <= COLOR;
          end
        end
        COLOR: if (fire) state <= NT;
        NT:    if (fire) state <= P0;
        P0:    if (fire) state <= P1;
        P1: begin
          if (fire) begin
            if (j_q == LAST_J) begin
              bus.line_done <= 1'b1;
              state         <= DONE;
            end else begin
              j_q   <= j_q + 6'd1;
              state <= NT;
            end
          end
        end
        DONE: begin
          bus.line_done <= 1'b0;
          bus.busy      <= 1'b0;
          front_sel     <= ~front_sel;
          front_fine    <= fine_q;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_line_fetcher.sv
// Directed bench for bg_line_fetcher: VRAM model, line fetches with and without
// scroll, flips, color select, stalled grants and a mid-fetch reset.
module tb_bg_line_fetcher;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bg_line_fetcher_if #(.ADDR_WIDTH(12)) bus ();

  bg_line_fetcher dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] vram [0:4095];
  bit gnt_rand = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk)
    bus.mem_data <= (bus.mem_req && bus.mem_gnt) ? vram[bus.mem_addr] : 8'hA5;

  always @(negedge clk)
    bus.mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] x, input logic [1:0] ep, input logic [2:0] ec);
    @(negedge clk);
    bus.px_x = x;
    @(negedge clk);
    chk({tag, "_pat"}, 32'(bus.px_pattern), 32'(ep));
    chk({tag, "_col"}, 32'(bus.px_color), 32'(ec));
  endtask

  task automatic run_line(input logic [7:0] ly, input logic [7:0] sy, input logic [7:0] sx,
                          input bit extra_start, output int done_at, output int ndone,
                          output logic [11:0] fnt, output logic [11:0] fpmb,
                          output logic busy1, output logic busy_after);
    bit got_nt, got_pmb;
    done_at = -1; ndone = 0; fnt = '0; fpmb = '0; busy1 = 1'b0; busy_after = 1'b1;
    got_nt = 1'b0; got_pmb = 1'b0;
    @(negedge clk);
    bus.line_y = ly; bus.scroll_y = sy; bus.scroll_x = sx; bus.line_start = 1'b1;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      bus.line_start = 1'b0;
      if (k == 1) busy1 = bus.busy;
      if (extra_start && k == 20) begin
        bus.line_start = 1'b1;
        bus.line_y = 8'd2;
      end
      if (bus.line_done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && k == done_at + 1) busy_after = bus.busy;
      if (bus.mem_req && !got_nt && bus.mem_addr >= 12'h400 && bus.mem_addr < 12'h7C0) begin
        fnt = bus.mem_addr; got_nt = 1'b1;
      end
      if (bus.mem_req && !got_pmb && bus.mem_addr >= 12'h200 && bus.mem_addr < 12'h400) begin
        fpmb = bus.mem_addr; got_pmb = 1'b1;
      end
      if (done_at >= 0 && k >= done_at + 8) break;
    end
  endtask

  // Row 0, no scroll: tile c in column c (column 3 selects color1).
  task automatic check_plain(input string tag);
    logic [1:0] exp_p [8];
    exp_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 8; i++) rd($sformatf("%s_px%0d", tag, i), 8'(i), exp_p[i], 3'd2);
    rd({tag, "_px23"}, 8'd23, 2'd0, 3'd2);
    rd({tag, "_px24"}, 8'd24, 2'd3, 3'd5);
    rd({tag, "_px25"}, 8'd25, 2'd0, 3'd5);
    rd({tag, "_px31"}, 8'd31, 2'd3, 3'd5);
    rd({tag, "_px32"}, 8'd32, 2'd0, 3'd2);
  endtask

  // scroll_x=0x0B, ry=6: entry j from column j+1, fine offset 3.
  task automatic check_scroll(input string tag);
    rd({tag, "_px0"},   8'd0,   2'd3, 3'd2);
    rd({tag, "_px4"},   8'd4,   2'd0, 3'd2);
    rd({tag, "_px5"},   8'd5,   2'd2, 3'd2);
    rd({tag, "_px12"},  8'd12,  2'd0, 3'd2);
    rd({tag, "_px13"},  8'd13,  2'd0, 3'd5);
    rd({tag, "_px252"}, 8'd252, 2'd1, 3'd2);
    rd({tag, "_px253"}, 8'd253, 2'd0, 3'd2);
    rd({tag, "_px254"}, 8'd254, 2'd1, 3'd2);
    rd({tag, "_px255"}, 8'd255, 2'd2, 3'd2);
  endtask

  int done_at, ndone;
  logic [11:0] fnt, fpmb;
  logic busy1, busy_after;

  initial begin
    bus.line_start = 1'b0; bus.line_y = '0; bus.scroll_x = '0; bus.scroll_y = '0; bus.px_x = '0;
    for (int a = 0; a < 4096; a++) vram[a] = 8'h00;
    vram[12'h7C0] = 8'h2A;
    for (int c = 0; c < 32; c++) vram[12'h400 + c] = 8'(c);
    vram[12'h403] = 8'h83;
    vram[12'h200] = 8'h1B; vram[12'h201] = 8'hE4;
    vram[12'h230] = 8'hC0; vram[12'h231] = 8'h03;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    chk("rst_line_done", 32'(bus.line_done),  32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),   32'd0);
    chk("rst_px_pat",    32'(bus.px_pattern), 32'd0);
    chk("rst_px_col",    32'(bus.px_color),   32'd0);
    rst = 1'b1;

    // Plain line, grant always high
    run_line(8'd0, 8'd0, 8'd0, 1'b0, done_at, ndone, fnt, fpmb, busy1, busy_after);
    chk("plain_done_at",  32'(done_at), 32'd101);
    chk("plain_ndone",    32'(ndone),   32'd1);
    chk("plain_busy_t1",  32'(busy1),   32'd1);
    chk("plain_busy_end", 32'(busy_after), 32'd0);
    chk("plain_first_nt", 32'(fnt),     32'h400);
    chk("plain_first_pm", 32'(fpmb),    32'h200);
    check_plain("plain");

    // Flips: tile 0x65 -> pattern 5, vflip row 7-2=5, hflip
    vram[12'h400] = 8'h65;
    vram[12'h25A] = 8'h1B; vram[12'h25B] = 8'h00;
    run_line(8'd2, 8'd0, 8'd0, 1'b0, done_at, ndone, fnt, fpmb, busy1, busy_after);
    chk("flip_done_at",  32'(done_at), 32'd101);
    chk("flip_first_pm", 32'(fpmb),    32'h25A);
    begin
      logic [1:0] fp [8];
      fp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
      for (int i = 0; i < 8; i++) rd($sformatf("flip_px%0d", i), 8'(i), fp[i], 3'd2);
    end
    vram[12'h400] = 8'h00;

    // Scroll with vertical wrap: 10+236-240 = 6
    vram[12'h21C] = 8'h1B; vram[12'h21D] = 8'hE4;
    vram[12'h22C] = 8'h80; vram[12'h22D] = 8'h00;
    vram[12'h20C] = 8'h00; vram[12'h20D] = 8'h01;
    run_line(8'd10, 8'd236, 8'h0B, 1'b0, done_at, ndone, fnt, fpmb, busy1, busy_after);
    chk("scroll_done_at",  32'(done_at), 32'd101);
    chk("scroll_first_nt", 32'(fnt),     32'h401);
    chk("scroll_first_pm", 32'(fpmb),    32'h21C);
    check_scroll("scroll");

    // Random stalls plus a start pulse while busy
    gnt_rand = 1'b1;
    run_line(8'd0, 8'd0, 8'd0, 1'b1, done_at, ndone, fnt, fpmb, busy1, busy_after);
    gnt_rand = 1'b0;
    chk("stall_ndone",    32'(ndone),      32'd1);
    chk("stall_busy_end", 32'(busy_after), 32'd0);
    check_plain("stall");

    // Reset in the middle of a fetch
    @(negedge clk);
    bus.line_y = 8'd10; bus.scroll_y = 8'd236; bus.scroll_x = 8'h0B; bus.line_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.line_start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy",    32'(bus.busy),      32'd0);
    chk("midrst_mem_req", 32'(bus.mem_req),   32'd0);
    chk("midrst_done",    32'(bus.line_done), 32'd0);
    rst = 1'b1;
    check_plain("midrst");

    run_line(8'd10, 8'd236, 8'h0B, 1'b0, done_at, ndone, fnt, fpmb, busy1, busy_after);
    chk("after_rst_done_at", 32'(done_at), 32'd101);
    chk("after_rst_ndone",   32'(ndone),   32'd1);
    check_scroll("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
